// File: rtl/final2_soc_oci_dct_pkg.sv
// Shared constants, state encoding and slot-placement helper for the OCI DCT trace sequencer.
package final2_soc_oci_dct_pkg;

  localparam int ATOM_W = 2;
  localparam int DEPTH  = 15;
  localparam int BUF_W  = ATOM_W * DEPTH;
  localparam int CNT_W  = 4;
  localparam int DROP_W = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } dct_state_t;

  // Returns a word with only slot 'slot' populated, so callers can OR it into the live buffer.
  function automatic logic [BUF_W-1:0] place_atom(input logic [ATOM_W-1:0] atom,
                                                  input logic [CNT_W-1:0]  slot);
    logic [BUF_W-1:0] word;
    word = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (slot == CNT_W'(k)) word[k*ATOM_W +: ATOM_W] = atom;
    end
    return word;
  endfunction

endpackage

// File: rtl/final2_soc_nios2_qsys_0_oci_dct_outreg.sv
// Output holding register: loads a packed trace word and holds it until the trace store takes it.
module final2_soc_nios2_qsys_0_oci_dct_outreg
  import final2_soc_oci_dct_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BUF_W-1:0] load_buffer,
  input  logic [CNT_W-1:0] load_count,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [BUF_W-1:0] out_buffer,
  output logic [CNT_W-1:0] out_count
);

  // A load always wins over a drop, so a consumed word can be replaced in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_buffer <= '0;
      out_count  <= '0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_buffer <= load_buffer;
      out_count  <= load_count;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/final2_soc_nios2_qsys_0_oci_dct_sequencer.sv
// Packs 2-bit OCI trace atoms into 30-bit words and sequences the end-of-test drain.
//  state | meaning
//  FILL  | packing atoms, words leave when the buffer is full
//  DRAIN | no new atoms; flush partial word, wait for output register to empty
//  DONE  | trace complete, test_has_ended held until reset
module final2_soc_nios2_qsys_0_oci_dct_sequencer
  import final2_soc_oci_dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              atom_valid,
  output logic              atom_ready,
  input  logic [ATOM_W-1:0] atom_data,
  input  logic              test_ending,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BUF_W-1:0]  out_buffer,
  output logic [CNT_W-1:0]  out_count,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              test_has_ended,
  output logic [DROP_W-1:0] atom_drop_cnt
);

  dct_state_t state;
  logic       xfer;
  logic       accept;
  logic       buf_full;
  logic       out_free;

  always_comb begin
    buf_full   = (dct_count == CNT_W'(DEPTH));
    out_free   = !out_valid || out_ready;
    xfer       = (buf_full || (state == DRAIN && dct_count != '0)) && out_free;
    // A full buffer still accepts when it is emptying this cycle: zero-bubble streaming.
    atom_ready = (state == FILL) && (!buf_full || xfer);
    accept     = atom_valid && atom_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FILL;
      dct_buffer     <= '0;
      dct_count      <= '0;
      test_has_ended <= 1'b0;
      atom_drop_cnt  <= '0;
    end else begin
      if (xfer) begin
        dct_buffer <= accept ? place_atom(atom_data, '0) : '0;
        dct_count  <= accept ? CNT_W'(1) : '0;
      end else if (accept) begin
        dct_buffer <= dct_buffer | place_atom(atom_data, dct_count);
        dct_count  <= dct_count + CNT_W'(1);
      end

      case (state)
        FILL: begin
          if (test_ending) state <= DRAIN;
        end
        DRAIN: begin
          if (dct_count == '0 && !out_valid) begin
            state          <= DONE;
            test_has_ended <= 1'b1;
          end
        end
        DONE: begin
          test_has_ended <= 1'b1;
        end
        default: state <= FILL;
      endcase

      if (atom_valid && state != FILL && atom_drop_cnt != '1)
        atom_drop_cnt <= atom_drop_cnt + DROP_W'(1);
    end
  end

  final2_soc_nios2_qsys_0_oci_dct_outreg u_outreg (
    .clk         (clk),
    .reset       (reset),
    .load        (xfer),
    .load_buffer (dct_buffer),
    .load_count  (dct_count),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_buffer  (out_buffer),
    .out_count   (out_count)
  );

endmodule
